video_frame_monitor: RTL and testbench
======================================

// Module: video_frame_monitor
// PURPOSE
// - Passive checker on the 1080p timing/pixel stream that drives the DDR frame-buffer input (vs/hs/de + r/g/b, pix clock domain).
// - Measures active pixels per line and active lines per frame, then compares them against the expected geometry.
// - Flags geometry errors, counts frames and errors, and optionally produces a per-frame pixel checksum.
// - Used in simulation benches and on-board as a debug tap ahead of the frame-write path.
// PARAMETERS
// - H_ACT      1920  expected active pixels per line (de high cycles)
// - V_ACT      1080  expected active lines per frame
// - CNT_W      12    width of pixel/line counters; counters saturate at 2^CNT_W-1
// - VS_POL     1     1: vs active-high, 0: vs active-low (normalised internally)
// PORTS
// - clk            in   1      pixel clock (148.5 MHz at 1080p)
// - rstn           in   1      asynchronous active-low reset
// - en             in   1      monitor enable; low forces IDLE, holds outputs
// - vs_in          in   1      frame sync
// - hs_in          in   1      line sync (registered only, not checked)
// - de_in          in   1      data valid
// - r_in/g_in/b_in in   8 each pixel data
// - frame_done     out  1      1-cycle pulse, result of completed frame valid
// - frame_ok       out  1      last frame matched H_ACT x V_ACT with no line error
// - line_err       out  1      sticky within current frame: some line length != H_ACT
// - meas_lines     out  CNT_W  active lines of last completed frame
// - meas_pix       out  CNT_W  pixel count of last completed line
// - frame_cnt      out  16     completed frames, wraps 0xFFFF->0
// - err_cnt        out  16     frames with frame_ok=0, saturates at 0xFFFF
// - checksum       out  16     per-frame checksum (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all counters 0.
// - All inputs registered once (stage 1); edges detected stage1 vs stage2.
// - vs_rise = normalised vs 0->1. de_rise/de_fall likewise.
// - FSM IDLE -> SYNC when en=1. SYNC -> RUN on first vs_rise (no report). RUN -> RUN on each vs_rise (report).
// - Any state -> IDLE when en=0. In IDLE, counters are cleared; outputs hold their last values.
// - RUN: pix_cnt increments each stage-1 de=1 cycle. On de_fall, meas_pix<=pix_cnt, line_cnt++.
// - RUN, line end: if pix_cnt != H_ACT then line_err<=1. pix_cnt cleared on de_rise.
// - RUN, on vs_rise: meas_lines<=line_cnt; frame_ok<=(line_cnt==V_ACT)&&!line_err&&!open_line.
// - RUN, on vs_rise (cont.): frame_done=1 next cycle; frame_cnt++; err_cnt++ if not ok; line_cnt, line_err, checksum accumulator cleared.
// - Latency: frame_done pulses exactly 3 clk after the vs_in rising edge at the port.
// - Simultaneous vs_rise while de=1 (open line): vs wins. Partial line is not counted in line_cnt and forces frame_ok=0.
// - Counter saturation: pix_cnt/line_cnt stop at all-ones; a saturated count never equals H_ACT/V_ACT (≤ 2^CNT_W-2 required).
// - de high outside a frame (SYNC state) is ignored.
// - Reset asserted mid-frame: immediate clear to reset values; first frame after release is not reported.
// CONFIGURATION
// - Macro VFM_CHECKSUM_EN.
// - Defined: accumulator += r_in+g_in+b_in (mod 2^16) for every RUN de=1 pixel. checksum<=acc at vs_rise, same cycle as meas_lines.
// - Undefined: no accumulator logic; checksum tied to 16'h0000.
// TESTING
// - 3 clean 1080p frames, rgb=0x1f each -> 2 frame_done pulses (first frame is sync only), frame_ok=1, meas_lines=1080, meas_pix=1920, err_cnt=0, frame_cnt=2.
// - Same with VFM_CHECKSUM_EN -> checksum=16'h9400 each reported frame. Without the macro -> checksum=0.
// - One line shortened to 1919 de cycles -> line_err=1 during frame; at vs_rise frame_ok=0, err_cnt=1. Next clean frame -> frame_ok=1, line_err=0.
// - Frame with 1079 lines -> meas_lines=1079, frame_ok=0.
// - vs_rise injected during de=1 -> frame_ok=0, meas_lines excludes partial line.
// - rstn pulled low mid-frame, then released -> all outputs 0. en=0 for 100 clk -> no frame_done. Next frame is sync only; the following frame is reported ok.
// - Check frame_done occurs 3 clk after the vs_in port edge.

Source files
------------

// File: rtl/video_frame_monitor.sv
// video_frame_monitor: passive line/frame geometry checker on a vs/hs/de pixel stream.
// Define VFM_CHECKSUM_EN to add the per-frame r+g+b checksum (otherwise checksum reads 0).
module video_frame_monitor #(
  parameter int H_ACT  = 1920,
  parameter int V_ACT  = 1080,
  parameter int CNT_W  = 12,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             vs_in,
  input  logic             hs_in,
  input  logic             de_in,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             line_err,
  output logic [CNT_W-1:0] meas_lines,
  output logic [CNT_W-1:0] meas_pix,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      checksum
);
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  localparam logic [CNT_W-1:0] H_C = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_C = CNT_W'(V_ACT);
  state_t state_q, state_d;
  logic en1_q, vs1_q, vs2_q, hs1_q, de1_q, de2_q;
  logic [CNT_W-1:0] pix_q, pix_d, line_q, line_d, mlines_q, mlines_d, mpix_q, mpix_d;
  logic [CNT_W-1:0] pix_inc, line_inc;
  logic lerr_q, lerr_d, ok_q, ok_d, rep_q, done_q;
  logic [15:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic run, vs_rise, de_rise, de_fall, report;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {en1_q, vs1_q, vs2_q, hs1_q, de1_q, de2_q} <= '0;
    else begin
      en1_q <= en;
      vs1_q <= VS_POL ? vs_in : ~vs_in;
      vs2_q <= vs1_q;
      hs1_q <= hs_in;
      de1_q <= de_in;
      de2_q <= de1_q;
    end
  assign run      = state_q == RUN;
  assign vs_rise  = vs1_q & ~vs2_q;
  assign de_rise  = de1_q & ~de2_q;
  assign de_fall  = ~de1_q & de2_q;
  assign report   = run & vs_rise;
  assign pix_inc  = &pix_q ? pix_q : pix_q + 1'b1;
  assign line_inc = &line_q ? line_q : line_q + 1'b1;
  // A line still open (or ending this very cycle) when vs rises is dropped and spoils the frame.
  always_comb begin
    state_d  = !en1_q ? IDLE : state_q == IDLE ? SYNC : (state_q == SYNC && vs_rise) ? RUN : state_q;
    pix_d    = (!run || report) ? '0 : de_rise ? CNT_W'(1) : de1_q ? pix_inc : pix_q;
    line_d   = (!run || report) ? '0 : de_fall ? line_inc : line_q;
    mpix_d   = (run && !report && de_fall) ? pix_q : mpix_q;
    lerr_d   = (report || (state_q == SYNC && vs_rise)) ? 1'b0 :
               (run && de_fall && pix_q != H_C) ? 1'b1 : lerr_q;
    ok_d     = report ? (line_q == V_C && !lerr_q && !(de1_q || de2_q)) : ok_q;
    mlines_d = report ? line_q : mlines_q;
    fcnt_d   = report ? fcnt_q + 1'b1 : fcnt_q;
    ecnt_d   = (report && !ok_d && ecnt_q != 16'hFFFF) ? ecnt_q + 1'b1 : ecnt_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q  <= IDLE;
      pix_q    <= '0;
      line_q   <= '0;
      mpix_q   <= '0;
      mlines_q <= '0;
      lerr_q   <= 1'b0;
      ok_q     <= 1'b0;
      rep_q    <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      mpix_q   <= mpix_d;
      mlines_q <= mlines_d;
      lerr_q   <= lerr_d;
      ok_q     <= ok_d;
      rep_q    <= report;
      done_q   <= rep_q;
      fcnt_q   <= fcnt_d;
      ecnt_q   <= ecnt_d;
    end
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign line_err   = lerr_q;
  assign meas_lines = mlines_q;
  assign meas_pix   = mpix_q;
  assign frame_cnt  = fcnt_q;
  assign err_cnt    = ecnt_q;
`ifdef VFM_CHECKSUM_EN
  logic [7:0] r1_q, g1_q, b1_q;
  logic [15:0] acc_q, acc_d, csum_q, csum_d;
  logic unused_hs;
  assign unused_hs = hs1_q;
  always_comb begin
    acc_d  = (!run || vs_rise) ? '0 : de1_q ? acc_q + 16'(r1_q) + 16'(g1_q) + 16'(b1_q) : acc_q;
    csum_d = report ? acc_q : csum_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      {r1_q, g1_q, b1_q} <= '0;
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      {r1_q, g1_q, b1_q} <= {r_in, g_in, b_in};
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  assign checksum = csum_q;
`else
  logic unused_in;
  assign unused_in = ^{hs1_q, r_in, g_in, b_in};
  assign checksum  = 16'h0000;
`endif
endmodule

// File: tb/tb_video_frame_monitor.sv
// tb_video_frame_monitor: randomized frames against a frame/line-level reference model.
module tb_video_frame_monitor;
  localparam int H = 12, V = 6, CW = 5, SAT = 31;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic frame_done, frame_ok, line_err;
  logic [CW-1:0] meas_lines, meas_pix;
  logic [15:0] frame_cnt, err_cnt, checksum;
  int checks = 0, errors = 0, done_total = 0, exp_done = 0;
  bit synced = 0, cur_err = 0, m_ok = 0;
  int cur_lines = 0, m_lines = 0, m_pix = 0;
  logic [15:0] cur_sum = '0, m_sum = '0, m_fcnt = '0, m_ecnt = '0;

  video_frame_monitor #(.H_ACT(H), .V_ACT(V), .CNT_W(CW), .VS_POL(1'b1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .frame_done(frame_done), .frame_ok(frame_ok),
    .line_err(line_err), .meas_lines(meas_lines), .meas_pix(meas_pix),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .checksum(checksum));

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) done_total++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(bit vs, bit de);
    vs_in = vs;
    de_in = de;
    hs_in = !de && ($urandom_range(0, 3) == 0);
    if (de) begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      if (synced) cur_sum += 16'(r_in) + 16'(g_in) + 16'(b_in);
    end
    @(negedge clk);
  endtask

  task automatic line(int len);
    repeat (3) step(0, 0);
    repeat (len) step(0, 1);
    if (synced) begin
      cur_lines = cur_lines < SAT ? cur_lines + 1 : SAT;
      m_pix = len < SAT ? len : SAT;
      if (len != H) cur_err = 1;
    end
  endtask

  task automatic frame(int n, int bad_idx, int bad_len);
    for (int l = 0; l < n; l++) line(l == bad_idx ? bad_len : H);
    repeat (3) step(0, 0);
    if (synced) chk("line_err_in_frame", line_err, cur_err);
  endtask

  task automatic vsync(int pre);
    int seen, at;
    bit rep, open;
    logic [15:0] exp_sum;
    seen = 0;
    at = -1;
    open = pre > 0;
    repeat (pre) step(0, 1);
    rep = synced && en;
    if (rep) begin
      m_lines = cur_lines;
      m_ok = (cur_lines == V) && !cur_err && !open;
      m_fcnt = m_fcnt + 16'd1;
      if (!m_ok && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
      m_sum = cur_sum;
      exp_done++;
    end
    if (en) begin
      synced = 1;
      cur_lines = 0;
      cur_err = 0;
      cur_sum = '0;
    end
    for (int i = 1; i <= 8; i++) begin
      step(i <= 3, open && i <= 2);
      if (frame_done === 1'b1) begin
        seen++;
        at = i;
      end
    end
`ifdef VFM_CHECKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 16'h0000;
`endif
    if (rep) begin
      chk("done_latency", at, 3);
      chk("done_width", seen, 1);
      chk("frame_ok", frame_ok, m_ok);
      chk("meas_lines", meas_lines, m_lines);
      chk("frame_cnt", frame_cnt, m_fcnt);
      chk("err_cnt", err_cnt, m_ecnt);
      chk("checksum", checksum, exp_sum);
      if (!open) begin
        chk("meas_pix", meas_pix, m_pix);
        chk("line_err_cleared", line_err, 0);
      end
    end else chk("no_done", seen, 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ok"}, frame_ok, 0);
    chk({tag, "_line_err"}, line_err, 0);
    chk({tag, "_lines"}, meas_lines, 0);
    chk({tag, "_pix"}, meas_pix, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
    chk({tag, "_ecnt"}, err_cnt, 0);
    chk({tag, "_csum"}, checksum, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1;
    en = 1;
    repeat (4) step(0, 0);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    frame(V, 2, H - 1);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    frame(V - 1, -1, 0);
    vsync(0);
    frame(V, V - 1, 40);
    vsync(0);
    frame(35, -1, 0);
    vsync(0);
    for (int k = 0; k < 4; k++) begin
      frame(V - 1 + $urandom_range(0, 2), $urandom_range(0, 1) ? $urandom_range(0, V - 1) : -1,
            H - 2 + $urandom_range(0, 4));
      vsync(0);
    end
    frame(V, -1, 0);
    vsync(3);
    repeat (6) step(0, 0);
    en = 0;
    synced = 0;
    cur_lines = 0;
    cur_err = 0;
    cur_sum = '0;
    repeat (20) step(0, 0);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    chk("en_low_fcnt_hold", frame_cnt, m_fcnt);
    en = 1;
    repeat (4) step(0, 0);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    line(H);
    repeat (3) step(0, 1);
    rstn = 0;
    synced = 0;
    cur_lines = 0;
    cur_err = 0;
    cur_sum = '0;
    m_pix = 0;
    m_fcnt = '0;
    m_ecnt = '0;
    step(0, 0);
    chk_zero("midreset");
    rstn = 1;
    repeat (4) step(0, 0);
    vsync(0);
    frame(V, -1, 0);
    vsync(0);
    repeat (4) step(0, 0);
    chk("done_total", done_total, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
